// File: rtl/sram_chunk_streamer_if.sv
// sram_chunk_streamer_if
//   Bundles the host-side write port, the burst command port and the
//   chunk output stream of sram_chunk_streamer.
//   master : host / sink side (drives writes, commands, abort, out_ready)
//   slave  : streamer side (drives start_ready, out_*, busy, done)
interface sram_chunk_streamer_if #(
  parameter int WORD_W  = 32,
  parameter int CHUNK_W = 9,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  start_len;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [CHUNK_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start_valid, start_addr, start_len,
           abort, out_ready,
    input  start_ready, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start_valid, start_addr, start_len,
           abort, out_ready,
    output start_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/sram_chunk_streamer.sv
// sram_chunk_streamer
//   Word-addressed SRAM (DEPTH x WORD_W, 1-cycle read latency, not cleared
//   by reset) with a burst read port that streams LEN consecutive words as
//   NCHUNK slices of CHUNK_W bits each, LSB slice first, over valid/ready.
// Ports
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : sram_chunk_streamer_if.slave
//          wr_en/wr_addr/wr_data   word write, IDLE only, addr >= DEPTH dropped
//          start_valid/ready/addr/len  burst command handshake
//          abort                   cancel an active burst, no done pulse
//          out_valid/ready/data/last   slice stream
//          busy, done              activity flag, completion pulse
module sram_chunk_streamer #(
  parameter int WORD_W  = 32,
  parameter int CHUNK_W = 9,
  parameter int NCHUNK  = 2,
  parameter int DEPTH   = 160,
  parameter int ADDR_W  = 8,
  parameter int LEN_W   = 8
) (
  input logic clk,
  input logic rst,
  sram_chunk_streamer_if.slave bus
);

  localparam int SH_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, EMIT} state_t;

  state_t state, state_nx;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [SH_W-1:0]   shreg;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  words_left;
  logic              done_q;

  logic start_fire;
  logic slice_fire;
  logic word_end;
  logic burst_end;

  // Bits of the read word above NCHUNK*CHUNK_W are never emitted.
  logic unused_word_bits;
  assign unused_word_bits = ^rd_word;

  assign start_fire = (state == IDLE) && !bus.wr_en && bus.start_valid;
  // abort wins over a same-cycle out_ready: the slice is not consumed.
  assign slice_fire = (state == EMIT) && bus.out_ready && !bus.abort;
  assign word_end   = (idx == IDX_LAST);
  assign burst_end  = word_end && (words_left == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_fire && (bus.start_len != '0)) state_nx = FETCH;
      FETCH: state_nx = bus.abort ? IDLE : LOAD;
      LOAD:  state_nx = bus.abort ? IDLE : EMIT;
      EMIT: begin
        if (bus.abort)                   state_nx = IDLE;
        else if (slice_fire && word_end) state_nx = burst_end ? IDLE : FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      idx        <= '0;
      shreg      <= '0;
      cur_addr   <= '0;
      words_left <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_fire) begin
            // Addresses in [DEPTH, 2*DEPTH) fold back with one subtract.
            cur_addr   <= (bus.start_addr >= DEPTH_A) ? bus.start_addr - DEPTH_A
                                                      : bus.start_addr;
            words_left <= bus.start_len;
            if (bus.start_len == '0) done_q <= 1'b1;
          end
        end
        LOAD: begin
          shreg <= rd_word[SH_W-1:0];
          idx   <= '0;
        end
        EMIT: begin
          if (slice_fire) begin
            shreg <= shreg >> CHUNK_W;
            idx   <= idx + 1'b1;
            if (word_end) begin
              if (burst_end) begin
                done_q <= 1'b1;
              end else begin
                cur_addr   <= (cur_addr == LAST_A) ? '0 : cur_addr + 1'b1;
                words_left <= words_left - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Single-port array: writes only happen in IDLE, reads only in FETCH.
  always_ff @(posedge clk) begin
    if (!rst && (state == IDLE) && bus.wr_en && (bus.wr_addr < DEPTH_A))
      mem[bus.wr_addr] <= bus.wr_data;
    if (state == FETCH)
      rd_word <= mem[cur_addr];
  end

  always_comb begin
    bus.out_valid   = (state == EMIT);
    bus.out_data    = (state == EMIT) ? shreg[CHUNK_W-1:0] : '0;
    bus.out_last    = (state == EMIT) && burst_end;
    bus.busy        = (state != IDLE);
    bus.start_ready = (state == IDLE) && !bus.wr_en;
    bus.done        = done_q;
  end

endmodule

// File: tb/tb_sram_chunk_streamer.sv
module tb_sram_chunk_streamer;

  localparam int WORD_W  = 32;
  localparam int CHUNK_W = 9;
  localparam int NCHUNK  = 2;
  localparam int DEPTH   = 160;
  localparam int ADDR_W  = 8;
  localparam int LEN_W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_chunk_streamer_if #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W),
                           .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  sram_chunk_streamer #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W), .NCHUNK(NCHUNK),
                        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic               last;
    logic               wend;
    logic [CHUNK_W-1:0] data;
  } slice_t;

  slice_t            exp_q[$];
  logic [WORD_W-1:0] mem_m [DEPTH];
  bit                m_active = 0;
  bit                m_done = 0;
  bit                armed = 0;
  int                m_gap = 0;

  logic [CHUNK_W:0]  act_log[$];
  int done_cnt = 0, done_cyc = -1, last_acc_cyc = -1, first_valid_cyc = -1;

  bit   rand_mode = 0;
  logic ready_force = 0;
  logic abort_force = 0;

  always @(negedge clk) begin : cmp
    bit     ve;
    bit     nd;
    slice_t s;
    int     base, a;
    logic [WORD_W-1:0] w;
    if (armed) begin
      ve = m_active && (m_gap == 0) && (exp_q.size() > 0);
      check("out_valid", bus.out_valid, ve);
      check("out_data", bus.out_data, ve ? exp_q[0].data : 0);
      check("out_last", bus.out_last, ve ? exp_q[0].last : 0);
      check("busy", bus.busy, m_active);
      check("done", bus.done, m_done);
      check("start_ready", bus.start_ready, !m_active && !bus.wr_en);
      if (!rst && bus.out_valid && bus.out_ready && !bus.abort) begin
        act_log.push_back({bus.out_last, bus.out_data});
        last_acc_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    // advance the model to the next cycle using this cycle's inputs
    if (rst) begin
      m_active = 0; exp_q.delete(); m_gap = 0; m_done = 0; armed = 1;
    end else if (armed) begin
      nd = 0;
      if (m_active) begin
        if (bus.abort) begin
          m_active = 0; exp_q.delete();
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (bus.out_ready) begin
          s = exp_q.pop_front();
          if (exp_q.size() == 0) begin m_active = 0; nd = 1; end
          else if (s.wend) m_gap = 2;
        end
      end else if (bus.wr_en) begin
        if (int'(bus.wr_addr) < DEPTH) mem_m[int'(bus.wr_addr)] = bus.wr_data;
      end else if (bus.start_valid) begin
        base = int'(bus.start_addr);
        if (base >= DEPTH) base -= DEPTH;
        if (bus.start_len == 0) nd = 1;
        else begin
          for (int i = 0; i < int'(bus.start_len); i++) begin
            a = (base + i) % DEPTH;
            w = mem_m[a];
            for (int k = 0; k < NCHUNK; k++) begin
              s.data = CHUNK_W'(w >> (k * CHUNK_W));
              s.wend = (k == NCHUNK - 1);
              s.last = s.wend && (i == int'(bus.start_len) - 1);
              exp_q.push_back(s);
            end
          end
          m_active = 1; m_gap = 2;
        end
      end
      m_done = nd;
    end
  end

  // Sink-side driver: out_ready and abort are only ever written here.
  initial begin
    bus.out_ready = 1'b0;
    bus.abort = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
      bus.abort = rand_mode ? ($urandom_range(0, 39) == 0) : abort_force;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_word(input int a, input logic [WORD_W-1:0] d);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input int a, input int l, output int acc, output int waited);
    @(posedge clk); #1;
    bus.start_valid = 1'b1; bus.start_addr = ADDR_W'(a); bus.start_len = LEN_W'(l);
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.start_ready) break;
      waited++;
    end
    check("start_ready_seen", bus.start_ready, 1);
    acc = cyc;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check("idle_within_bound", bus.busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("valid_within_bound", bus.out_valid, 1);
  endtask

  task automatic check_log(input string tag, input logic [CHUNK_W:0] e[$]);
    check({tag, "_count"}, act_log.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      check($sformatf("%s_slice%0d", tag, i),
            (i < act_log.size()) ? longint'(act_log[i]) : -1, e[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int acc, waited, d0;
    logic [CHUNK_W:0] e[$];

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start_valid = 1'b0; bus.start_addr = '0; bus.start_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_start_ready", bus.start_ready, 1);

    for (int a = 0; a < DEPTH; a++) write_word(a, $urandom);

    // single-word burst
    write_word(5, 32'h0003_FE01);
    ready_force = 1'b1;
    act_log.delete(); first_valid_cyc = -1;
    do_start(5, 1, acc, waited);
    wait_idle();
    e = '{10'h001, 10'h3FF};
    check_log("burst5", e);
    check("first_valid_latency", first_valid_cyc - acc, 3);
    check("done_after_last", done_cyc - last_acc_cyc, 1);
    check("start_ready_back", bus.start_ready, 1);

    // wrap 159 -> 0
    write_word(158, 32'hABC0_4411);
    write_word(159, 32'hABC0_8833);
    write_word(0,   32'hABC1_5555);
    act_log.delete();
    do_start(158, 3, acc, waited);
    wait_idle();
    e = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h155, 10'h2AA};
    check_log("wrap", e);

    // backpressure on the first slice
    ready_force = 1'b0;
    act_log.delete();
    do_start(158, 3, acc, waited);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, 9'h011);
    end
    @(posedge clk); #1 ready_force = 1'b1;
    wait_idle();
    check_log("backpressure", e);

    // abort during word 2 of 4
    act_log.delete(); d0 = done_cnt;
    do_start(10, 4, acc, waited);
    for (int i = 0; i < 100 && act_log.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1 ready_force = 1'b0;
    wait_valid();
    @(posedge clk); #1 abort_force = 1'b1; ready_force = 1'b1;
    @(posedge clk); #1 abort_force = 1'b0;
    @(negedge clk);
    check("abort_idle", bus.busy, 0);
    check("abort_valid", bus.out_valid, 0);
    check("abort_slices", act_log.size(), 2);
    check("abort_no_done", done_cnt, d0);
    act_log.delete();
    do_start(40, 2, acc, waited);
    check("restart_wait", waited, 0);
    wait_idle();
    check("restart_slices", act_log.size(), 4);
    check("restart_done", done_cnt, d0 + 1);

    // zero-length burst
    act_log.delete(); d0 = done_cnt;
    do_start(20, 0, acc, waited);
    repeat (3) begin
      @(negedge clk);
      check("len0_busy", bus.busy, 0);
    end
    check("len0_done", done_cnt, d0 + 1);
    check("len0_slices", act_log.size(), 0);

    // write has priority over a same-cycle start
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 8'd30; bus.wr_data = 32'h0001_2345;
    bus.start_valid = 1'b1; bus.start_addr = 8'd30; bus.start_len = 8'd1;
    @(negedge clk);
    check("wr_start_ready", bus.start_ready, 0);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.start_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wr_start_not_taken", bus.busy, 0);
    end
    act_log.delete();
    do_start(30, 1, acc, waited);
    wait_idle();
    e = '{10'h145, 10'h291};
    check_log("wr_prio_readback", e);

    // reset in the middle of EMIT
    ready_force = 1'b0;
    do_start(158, 3, acc, waited);
    wait_valid();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_last", bus.out_last, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    ready_force = 1'b1;
    act_log.delete();
    do_start(158, 3, acc, waited);
    wait_idle();
    e = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h155, 10'h2AA};
    check_log("post_rst", e);

    // randomized traffic
    rand_mode = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 3)
        repeat ($urandom_range(1, 3)) write_word($urandom_range(0, 255), $urandom);
      do_start($urandom_range(0, 255), $urandom_range(0, 6), acc, waited);
      wait_idle();
    end
    rand_mode = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
